// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg -- shared definitions for the PWM generator slice.
//   PWM_WIDTH_DEF : default counter/duty width in bits
//   pwm_state_e   : duty-update handshake FSM encoding (IDLE=0, PENDING=1)
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det -- two-flop synchronizer followed by a registered rising-edge
// detector. One-clock pulse on rise three clocks after d goes high.
// Ports:
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-high reset
//   d    : asynchronous level input (e.g. divider clk_out)
//   rise : one-clk pulse per rising edge of d
// Only instantiated by pwm_gen when PWM_GEN_EDGE_DETECT_EN is defined.
// -----------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronize d into the clk domain and register its rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise    <= sync2_r & ~prev_r;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen -- counter-compare PWM generator with a glitch-free, handshaked
// duty update. A new duty value is parked in a shadow register and only
// becomes active at the next period wrap, so a period never mixes two duties.
//
// Parameters:
//   WIDTH       : counter and duty width; period is 2^WIDTH strobes
// Ports:
//   clk         : system clock (rising edge)
//   rst         : asynchronous active-high reset
//   tick_in     : advance strobe, or divider clk_out level when
//                 PWM_GEN_EDGE_DETECT_EN is defined
//   duty_in     : requested duty value
//   duty_valid  : duty_in valid
//   duty_ready  : block can accept a duty value
//   pwm_out     : registered PWM waveform (cnt < duty_cur)
//   period_done : one-clk pulse after each period wrap
//
// Build option:
//   PWM_GEN_EDGE_DETECT_EN : tick_in is a level; the strobe is derived by
//                            synchronizing it and detecting rising edges.
// -----------------------------------------------------------------------------
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_done
);

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    logic             strobe_s;
    logic             wrap_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] duty_cur_r;
    logic [WIDTH-1:0] shadow_r;
    pwm_state_e       state_r;

`ifdef PWM_GEN_EDGE_DETECT_EN
    edge_det u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .d    (tick_in),
        .rise (strobe_s)
    );
`else
    assign strobe_s = tick_in;
`endif

    // A wrap is the strobe that takes the counter from all-ones back to zero
    assign wrap_s = strobe_s && (cnt_r == CNT_LAST);

    // Period counter, duty handshake FSM and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            duty_cur_r  <= CNT_ZERO;
            shadow_r    <= CNT_ZERO;
            state_r     <= IDLE;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
            duty_ready  <= 1'b1;
        end else begin
            if (strobe_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            pwm_out     <= (cnt_r < duty_cur_r);
            period_done <= wrap_s;

            case (state_r)
                IDLE: begin
                    // A transfer coinciding with a wrap only loads the shadow;
                    // it is applied at the following wrap.
                    if (duty_valid) begin
                        shadow_r   <= duty_in;
                        state_r    <= PENDING;
                        duty_ready <= 1'b0;
                    end else begin
                        state_r    <= IDLE;
                        duty_ready <= 1'b1;
                    end
                end
                PENDING: begin
                    // duty_valid is ignored here; the shadow is held until wrap
                    if (wrap_s) begin
                        duty_cur_r <= shadow_r;
                        state_r    <= IDLE;
                        duty_ready <= 1'b1;
                    end else begin
                        state_r    <= PENDING;
                        duty_ready <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    duty_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen -- self-checking bench for pwm_gen (WIDTH=8). A behavioural
// model (strobe count modulo 256, a queue holding the pending duty) predicts
// pwm_out/period_done/duty_ready every cycle; scenario tasks additionally
// check high-time per period and wrap timing.
// -----------------------------------------------------------------------------
module tb_pwm_gen;

    localparam int W = 8;
    localparam int N = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_in;
    logic [W-1:0] duty_in;
    logic         duty_valid;
    logic         duty_ready;
    logic         pwm_out;
    logic         period_done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int   m_cnt;
    int   m_duty;
    int   pend_q[$];
    bit   e_pwm, e_pd, e_rdy;
`ifdef PWM_GEN_EDGE_DETECT_EN
    bit   h1, h2, h3, h4;
`endif

    int       cyc;
    int       mm_cnt;
    int       mm_cyc;
    logic [2:0] mm_got, mm_exp;
    int       hi_cnt;
    int       pd_cnt;

    pwm_gen #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt  = 0;
        m_duty = 0;
        pend_q.delete();
        e_pwm = 1'b0;
        e_pd  = 1'b0;
        e_rdy = 1'b1;
`ifdef PWM_GEN_EDGE_DETECT_EN
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; h4 = 1'b0;
`endif
    endtask

    // One clock: predict from the current inputs, clock the DUT, sample at negedge
    task automatic step();
        bit strobe, wrap, n_pwm;
`ifdef PWM_GEN_EDGE_DETECT_EN
        strobe = h3 && !h4;
        h4 = h3; h3 = h2; h2 = h1; h1 = (tick_in === 1'b1);
`else
        strobe = (tick_in === 1'b1);
`endif
        wrap  = strobe && (m_cnt == N - 1);
        n_pwm = (m_cnt < m_duty);
        if (strobe) m_cnt = (m_cnt + 1) % N;
        if (pend_q.size() != 0 && wrap)
            m_duty = pend_q.pop_front();
        else if (pend_q.size() == 0 && duty_valid === 1'b1)
            pend_q.push_back(int'(duty_in));
        e_pwm = n_pwm;
        e_pd  = wrap;
        e_rdy = (pend_q.size() == 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if ({pwm_out, period_done, duty_ready} !== {e_pwm, e_pd, e_rdy}) begin
            if (mm_cnt == 0) begin
                mm_cyc = cyc;
                mm_got = {pwm_out, period_done, duty_ready};
                mm_exp = {e_pwm, e_pd, e_rdy};
            end
            mm_cnt++;
        end
        if (pwm_out === 1'b1) hi_cnt++;
        if (period_done === 1'b1) pd_cnt++;
    endtask

    task automatic offer(input int v);
        duty_in    = v[W-1:0];
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        duty_in    = W'($urandom_range(0, N - 1));
    endtask

    task automatic wait_wrap(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * N; i++) begin
            step();
            if (period_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        n_checks++;
        if (period_done !== 1'b0) begin n_fail++; $display("FAIL reset_pd: got %b expected 0", period_done); end
        n_checks++;
        if (duty_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", duty_ready); end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_duty64();
        mm_cnt = 0;
        tick_in = 1'b1;
        offer(64);
        repeat (N - 1) step();
        n_checks++;
        if (period_done !== 1'b1) begin n_fail++; $display("FAIL duty64_first_wrap: period_done=%b expected 1 at clk 256", period_done); end
        for (int p = 0; p < 2; p++) begin
            hi_cnt = 0; pd_cnt = 0;
            repeat (N) step();
            n_checks++;
            if (hi_cnt != 64) begin n_fail++; $display("FAIL duty64_high: got %0d high clks expected 64", hi_cnt); end
            n_checks++;
            if (pd_cnt != 1 || period_done !== 1'b1) begin n_fail++; $display("FAIL duty64_pd: got %0d pulses, last=%b expected 1 at clk 256", pd_cnt, period_done); end
        end
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL duty64_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask

    task automatic test_duty_0_255();
        bit ok;
        mm_cnt = 0;
        offer(0);
        wait_wrap(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL d0_wrap_timeout: got none expected wrap"); end
        hi_cnt = 0; pd_cnt = 0;
        offer(255);
        repeat (N - 1) step();
        n_checks++;
        if (hi_cnt != 0) begin n_fail++; $display("FAIL d0_high: got %0d expected 0", hi_cnt); end
        hi_cnt = 0; pd_cnt = 0;
        repeat (N) step();
        n_checks++;
        if (hi_cnt != 255) begin n_fail++; $display("FAIL d255_high: got %0d expected 255", hi_cnt); end
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL d0_255_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask

    task automatic test_pending_drop();
        bit ok;
        mm_cnt = 0;
        repeat (50) step();
        offer(100);
        n_checks++;
        if (duty_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready1: got %b expected 0", duty_ready); end
        offer(200);
        n_checks++;
        if (duty_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready2: got %b expected 0", duty_ready); end
        wait_wrap(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pend_wrap_timeout: got none expected wrap"); end
        hi_cnt = 0;
        repeat (N) step();
        n_checks++;
        if (hi_cnt != 100) begin n_fail++; $display("FAIL pend_high: got %0d expected 100", hi_cnt); end
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL pend_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask

    task automatic test_coincident();
        mm_cnt = 0;
        repeat (N - 1) step();
        offer(30);
        n_checks++;
        if (period_done !== 1'b1 || duty_ready !== 1'b0) begin
            n_fail++; $display("FAIL coinc_edge: got pd=%b ready=%b expected pd=1 ready=0", period_done, duty_ready);
        end
        hi_cnt = 0;
        repeat (N) step();
        n_checks++;
        if (hi_cnt != 100) begin n_fail++; $display("FAIL coinc_old: got %0d expected 100", hi_cnt); end
        hi_cnt = 0;
        repeat (N) step();
        n_checks++;
        if (hi_cnt != 30) begin n_fail++; $display("FAIL coinc_new: got %0d expected 30", hi_cnt); end
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL coinc_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask

    task automatic test_random();
        mm_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            tick_in    = ($urandom_range(0, 3) != 0);
            duty_valid = ($urandom_range(0, 15) == 0);
            duty_in    = W'($urandom_range(0, N - 1));
            step();
        end
        duty_valid = 1'b0;
        tick_in    = 1'b1;
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL random_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask

    task automatic test_reset_pending();
        bit ok1, ok2;
        mm_cnt = 0;
        tick_in = 1'b1;
        wait_wrap(ok1);
        offer(200);
        wait_wrap(ok2);
        n_checks++;
        if (!(ok1 && ok2)) begin n_fail++; $display("FAIL rstp_wrap_timeout: got %b%b expected 11", ok1, ok2); end
        repeat (9) step();
        offer(77);
        repeat (120) step();
        n_checks++;
        if (pwm_out !== 1'b1 || duty_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstp_pre: got pwm=%b ready=%b expected pwm=1 ready=0", pwm_out, duty_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({pwm_out, period_done, duty_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rstp_async: got pwm/pd/rdy=%b expected 001", {pwm_out, period_done, duty_ready});
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hi_cnt = 0; pd_cnt = 0;
        repeat (N) step();
        n_checks++;
        if (pd_cnt != 1 || period_done !== 1'b1) begin n_fail++; $display("FAIL rstp_first_wrap: got %0d pulses last=%b expected 1 at clk 256", pd_cnt, period_done); end
        n_checks++;
        if (hi_cnt != 0) begin n_fail++; $display("FAIL rstp_high1: got %0d expected 0", hi_cnt); end
        hi_cnt = 0;
        repeat (N) step();
        n_checks++;
        if (hi_cnt != 0) begin n_fail++; $display("FAIL rstp_lost: got %0d expected 0", hi_cnt); end
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL rstp_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask

`ifdef PWM_GEN_EDGE_DETECT_EN
    task automatic test_edge_detect();
        int first_pd, second_pd;
        mm_cnt = 0;
        first_pd = -1; second_pd = -1;
        hi_cnt = 0;
        for (int i = 0; i < 4100; i++) begin
            tick_in    = ((i % 8) < 4);
            duty_valid = (i == 0);
            duty_in    = 8'd1;
            if (i == 2044) hi_cnt = 0;
            step();
            if (period_done === 1'b1) begin
                if (first_pd < 0) first_pd = i + 1;
                else if (second_pd < 0) second_pd = i + 1;
            end
            if (i == 4091) pd_cnt = hi_cnt;
        end
        duty_valid = 1'b0;
        n_checks++;
        if (first_pd != 2044) begin n_fail++; $display("FAIL edge_first_wrap: got clk %0d expected 2044", first_pd); end
        n_checks++;
        if (second_pd != 4092) begin n_fail++; $display("FAIL edge_second_wrap: got clk %0d expected 4092", second_pd); end
        n_checks++;
        if (pd_cnt != 8) begin n_fail++; $display("FAIL edge_cnt0_clks: got %0d expected 8", pd_cnt); end
        n_checks++;
        if (mm_cnt != 0) begin n_fail++; $display("FAIL edge_model: %0d mismatches, first cyc %0d got %b expected %b", mm_cnt, mm_cyc, mm_got, mm_exp); end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        tick_in    = 1'b0;
        duty_in    = 8'd0;
        duty_valid = 1'b0;
        cyc    = 0;
        mm_cnt = 0;
        hi_cnt = 0;
        pd_cnt = 0;
        model_reset();
        test_reset();
`ifdef PWM_GEN_EDGE_DETECT_EN
        test_edge_detect();
        test_random();
`else
        test_duty64();
        test_duty_0_255();
        test_pending_drop();
        test_coincident();
        test_random();
        test_reset_pending();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter and duty width in bits (period = 2^WIDTH ticks).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port tick_in, input, 1, advance strobe from the upstream clock divider, or its clk_out level when PWM_GEN_EDGE_DETECT_EN is defined.
REQ-005 SHALL have port duty_in, input, WIDTH, requested duty value.
REQ-006 SHALL have port duty_valid, input, 1, duty_in valid.
REQ-007 SHALL have port duty_ready, output, 1, block can accept a duty value.
REQ-008 SHALL have port pwm_out, output, 1, registered PWM waveform.
REQ-009 SHALL have port period_done, output, 1, one-clk pulse at each period wrap.

Function
REQ-010 SHALL keep counter cnt (WIDTH bits) advancing by 1 only in clk cycles where the internal strobe is high, holding otherwise.
REQ-011 SHALL wrap cnt from 2^WIDTH-1 to 0 on a strobe and pulse period_done high for exactly that following clk cycle.
REQ-012 SHALL drive pwm_out <= (cnt < duty_cur) every clk: one clk latency from cnt/duty_cur change.
REQ-013 SHALL give duty_cur=0 -> pwm_out constantly low; duty_cur=2^WIDTH-1 -> high for 2^WIDTH-1 of 2^WIDTH ticks.
REQ-014 SHALL accept duty_in into shadow register when duty_valid && duty_ready (handshake transfer).
REQ-015 SHALL run FSM with states IDLE (no pending shadow, duty_ready=1) and PENDING (shadow held, duty_ready=0).
REQ-016 SHALL transition IDLE->PENDING on a transfer; PENDING->IDLE on the wrap strobe, copying shadow into duty_cur in that same edge.
REQ-017 SHALL, on transfer in the same cycle as a wrap strobe in IDLE, store to shadow only; apply at the next wrap, never the current one.
REQ-018 SHALL ignore duty_valid while PENDING; duty_in need not be held.
REQ-019 SHALL keep duty_cur stable within a period (glitch-free duty update).

Reset
REQ-020 SHALL on rst clear cnt, duty_cur, shadow to 0, state to IDLE, pwm_out=0, period_done=0, duty_ready=1 immediately (asynchronous).
REQ-021 SHALL, on reset mid-period or while PENDING, discard the pending shadow; first period after release starts at cnt=0.

Configuration
REQ-022 SHALL, with PWM_GEN_EDGE_DETECT_EN defined, pass tick_in through a 2-flop synchronizer and rising-edge detector; strobe = one clk per tick_in rising edge, 3 clk latency.
REQ-023 SHALL, without PWM_GEN_EDGE_DETECT_EN, use tick_in directly as the strobe (caller guarantees single-clk pulses).

Structure
REQ-024 SHALL place the FSM state encoding (IDLE=0, PENDING=1) and the default width constant PWM_WIDTH_DEF=8 in shared package pwm_pkg.
REQ-025 SHALL implement synchronizer/edge detection as sub-module edge_det (ports clk, rst, d, rise), instantiated only under the macro.

Verification
REQ-026 SHALL check: WIDTH=8, tick_in=1 constant (macro off), duty 64 loaded at reset exit -> pwm_out high 64 of every 256 clks, period_done every 256 clks.
REQ-027 SHALL check: duty 0 then 255 -> pwm_out never high; then high 255/256 after next wrap.
REQ-028 SHALL check: duty 100 accepted mid-period, duty 200 offered while PENDING -> duty_ready=0, 200 dropped; 100 takes effect at wrap.
REQ-029 SHALL check: transfer coincident with wrap strobe -> old duty for the next full period, new duty from the following period.
REQ-030 SHALL check: macro on, tick_in = divider square wave, period 8 clks -> cnt advances once per 8 clks, first strobe 3 clks after rising edge.
REQ-031 SHALL check: rst asserted at cnt=130 while PENDING -> all outputs reset same cycle, duty_ready=1, pending value lost.
